// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-display blocks.
// Holds the arbiter state encoding, the index-width helper and the default dwell length.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OPEN,
        PIN
    } arb_state_t;

    // About one second of dwell at 50 MHz.
    localparam int unsigned DEFAULT_HOLD_CYCLES = 1024 * 1024 * 50;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: scans req upward from start with wrap-around,
// optionally skipping one excluded index, and returns the first hit.
module rr_priority_pick
    import debug_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    start,
    input  logic [IW-1:0]    excl,
    input  logic             excl_en,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    int          pos;
    logic [IW-1:0] pos_idx;

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        valid   = 1'b0;
        winner  = '0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            pos = int'(start) + i;
            if (pos >= int'(N_REQ)) begin
                pos = pos - int'(N_REQ);
            end
            pos_idx = IW'(pos);
            if (!valid && req[pos_idx] && !(excl_en && (pos_idx == excl))) begin
                valid  = 1'b1;
                winner = pos_idx;
            end
        end
    end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner arbitration for the shared 8-LED debug display with a minimum dwell.
// Define LED_ARB_PIN_EN to compile the click-driven pin (freeze owner) feature.
module led_share_arbiter
    import debug_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [WIDTH-1:0]          i_data [N_REQ-1:0],
    input  logic                      i_click,
    output logic [N_REQ-1:0]          o_grant,
    output logic [$clog2(N_REQ)-1:0]  o_owner,
    output logic [WIDTH-1:0]          o_led,
    output logic                      o_pinned,
    output logic                      o_busy
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic            busy_q, busy_d;
    logic            click_rise;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   pick_start;

    // Scan starts just past the previous owner; the current owner is never re-picked.
    assign pick_start = (last_q == IW'(N_REQ - 1)) ? '0 : last_q + IW'(1);

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (i_req),
        .start   (pick_start),
        .excl    (owner_q),
        .excl_en (state_q != IDLE),
        .valid   (pick_valid),
        .winner  (pick_idx)
    );

`ifdef LED_ARB_PIN_EN
    logic click_q, click_d;
    logic click_prev_q, click_prev_d;

    assign click_d      = i_click;
    assign click_prev_d = click_q;
    assign click_rise   = click_q & ~click_prev_q;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            click_q      <= 1'b0;
            click_prev_q <= 1'b0;
        end else begin
            click_q      <= click_d;
            click_prev_q <= click_prev_d;
        end
    end

    assign o_pinned = (state_q == PIN);
`else
    logic unused_click;
    assign unused_click = i_click;
    assign click_rise   = 1'b0;
    assign o_pinned     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = HOLD;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (click_rise) begin
                    state_d = PIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_d = OPEN;
                    end
                end
            end
            OPEN: begin
                // A pin request takes precedence over any re-arbitration this cycle.
                if (click_rise) begin
                    state_d = PIN;
                end else if (pick_valid) begin
                    state_d = HOLD;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end else if (!i_req[owner_q]) begin
                    state_d = IDLE;
                end
            end
`ifdef LED_ARB_PIN_EN
            PIN: begin
                if (click_rise) begin
                    state_d = OPEN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        grant_d = '0;
        led_d   = '0;
        if (busy_d) begin
            grant_d[owner_d] = 1'b1;
            led_d            = i_data[owner_d];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant = grant_q;
    assign o_owner = owner_q;
    assign o_led   = led_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter: expected owners are queued with the stimulus
// and compared against grant events captured by a negedge monitor.
module tb_led_share_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         i_reset = 1'b0;
    logic [N-1:0] i_req = '0;
    logic [W-1:0] i_data [N-1:0];
    logic         i_click = 1'b0;
    logic [N-1:0] o_grant;
    logic [1:0]   o_owner;
    logic [W-1:0] o_led;
    logic         o_pinned;
    logic         o_busy;

    int checks = 0;
    int errors = 0;

    int           exp_q[$];
    int           obs_owner_q[$];
    logic [N-1:0] obs_grant_q[$];
    logic [W-1:0] obs_led_q[$];
    int           ten_q[$];

    always #5 clk = ~clk;

    led_share_arbiter #(.WIDTH(W), .N_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_req    (i_req),
        .i_data   (i_data),
        .i_click  (i_click),
        .o_grant  (o_grant),
        .o_owner  (o_owner),
        .o_led    (o_led),
        .o_pinned (o_pinned),
        .o_busy   (o_busy)
    );

    // Grant-event monitor: records each new owner and the length of each finished tenure.
    logic [N-1:0] prev_grant = '0;
    int           tenure = 0;
    always @(negedge clk) begin
        if (o_grant !== prev_grant) begin
            if (prev_grant != '0) ten_q.push_back(tenure);
            if (o_grant != '0) begin
                obs_owner_q.push_back(int'(o_owner));
                obs_grant_q.push_back(o_grant);
                obs_led_q.push_back(o_led);
            end
            tenure = 1;
        end else begin
            tenure = tenure + 1;
        end
        prev_grant = o_grant;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_queues();
        exp_q.delete();
        obs_owner_q.delete();
        obs_grant_q.delete();
        obs_led_q.delete();
        ten_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b0;
        i_req   = '0;
        i_click = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        clear_queues();
    endtask

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (obs_owner_q.size() > 0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
        ok = (obs_owner_q.size() > 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%b required 0", tag, o_busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        checks += 5;
        if (o_grant !== '0) begin errors++; $display("FAIL reset_grant got %b required 0000", o_grant); end
        if (o_owner !== '0) begin errors++; $display("FAIL reset_owner got %0d required 0", o_owner); end
        if (o_led   !== '0) begin errors++; $display("FAIL reset_led got %h required 00", o_led); end
        if (o_pinned !== 1'b0) begin errors++; $display("FAIL reset_pinned got %b required 0", o_pinned); end
        if (o_busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", o_busy); end
        i_reset = 1'b1;
    endtask

    task automatic test_dwell();
        bit ok;
        int ob;
        do_reset();
        i_req = 4'b0001;
        exp_q.push_back(0);
        wait_obs(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dwell_grant timeout required owner 0");
            return;
        end
        ob = exp_q.pop_front();
        checks += 3;
        if (obs_owner_q.pop_front() !== ob) begin errors++; $display("FAIL dwell_owner got %0d required %0d", o_owner, ob); end
        if (obs_grant_q.pop_front() !== 4'b0001) begin errors++; $display("FAIL dwell_grant got %b required 0001", o_grant); end
        if (obs_led_q.pop_front() !== 8'hA5) begin errors++; $display("FAIL dwell_led got %h required a5", o_led); end
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) i_req = '0;
            checks++;
            if (o_grant !== 4'b0001) begin errors++; $display("FAIL dwell_hold cycle %0d got %b required 0001", i, o_grant); end
        end
        @(negedge clk);
        #1;
        checks += 3;
        if (o_grant !== '0) begin errors++; $display("FAIL release_grant got %b required 0000", o_grant); end
        if (o_led !== '0) begin errors++; $display("FAIL release_led got %h required 00", o_led); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b required 0", o_busy); end
        @(negedge clk);
        #1;
        checks++;
        if (ten_q.size() != 1 || ten_q[0] != H + 1) begin
            errors++;
            $display("FAIL dwell_tenure got %0d entries first %0d required %0d", ten_q.size(), (ten_q.size() > 0) ? ten_q[0] : -1, H + 1);
        end
    endtask

    task automatic test_rotation();
        bit ok;
        int e;
        int ob;
        do_reset();
        i_req = 4'b1111;
        exp_q = '{0, 1, 2, 3, 0};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rot_owner timeout required %0d", e); break; end
            ob = obs_owner_q.pop_front();
            checks += 2;
            if (ob !== e) begin errors++; $display("FAIL rot_owner got %0d required %0d", ob, e); end
            if (obs_grant_q.pop_front() !== 4'(1 << e)) begin errors++; $display("FAIL rot_grant owner %0d not one-hot match", e); end
            checks++;
            if (obs_led_q.pop_front() !== i_data[e]) begin errors++; $display("FAIL rot_led owner %0d required %h", e, i_data[e]); end
        end
        checks++;
        if (ten_q.size() < 4) begin
            errors++;
            $display("FAIL rot_tenure_count got %0d required 4", ten_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ten_q[i] != H + 1) begin errors++; $display("FAIL rot_tenure %0d got %0d required %0d", i, ten_q[i], H + 1); end
            end
        end
        i_req = '0;
        wait_idle("rot");
    endtask

    task automatic test_skip_wrap();
        bit ok;
        int e;
        int ob;
        do_reset();
        i_req = 4'b1000;
        exp_q = '{3, 0, 2};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL skip_owner timeout required %0d", e); break; end
            ob = obs_owner_q.pop_front();
            void'(obs_grant_q.pop_front());
            void'(obs_led_q.pop_front());
            checks++;
            if (ob !== e) begin errors++; $display("FAIL skip_owner got %0d required %0d", ob, e); end
            if (ob == 3) i_req = 4'b0101;
        end
        i_req = '0;
        wait_idle("skip");
    endtask

`ifdef LED_ARB_PIN_EN
    task automatic test_pin();
        bit ok;
        int e;
        int ob;
        int bad;
        do_reset();
        i_click = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_pinned !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL idle_click pinned=%b busy=%b required 0 0", o_pinned, o_busy); end
        i_click = 1'b0;
        repeat (2) @(negedge clk);
        clear_queues();
        i_req = 4'b1111;
        exp_q = '{0, 1};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_obs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL pin_owner timeout required %0d", e); return; end
            ob = obs_owner_q.pop_front();
            void'(obs_grant_q.pop_front());
            void'(obs_led_q.pop_front());
            checks++;
            if (ob !== e) begin errors++; $display("FAIL pin_owner got %0d required %0d", ob, e); end
        end
        i_click = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (o_pinned !== 1'b1) begin errors++; $display("FAIL pin_set got %b required 1", o_pinned); end
        if (o_owner !== 2'd1) begin errors++; $display("FAIL pin_owner_frozen got %0d required 1", o_owner); end
        i_click = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (o_grant !== 4'b0010 || o_pinned !== 1'b1 || o_led !== i_data[1]) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL pin_hold bad cycles %0d required 0", bad); end
        if (obs_owner_q.size() != 0) begin errors++; $display("FAIL pin_hold grant events %0d required 0", obs_owner_q.size()); end
        @(negedge clk);
        i_click = 1'b1;
        exp_q.push_back(2);
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (o_pinned !== 1'b0) begin errors++; $display("FAIL unpin got %b required 0", o_pinned); end
        if (o_owner !== 2'd1) begin errors++; $display("FAIL unpin_owner got %0d required 1", o_owner); end
        i_click = 1'b0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (int'(o_owner) !== e || o_grant !== 4'b0100) begin
            errors++;
            $display("FAIL unpin_rotate got owner %0d grant %b required %0d 0100", o_owner, o_grant, e);
        end
        i_req = '0;
        wait_idle("pin");
    endtask
`else
    task automatic test_click_ignored();
        int e;
        int ob;
        int bad;
        int cyc;
        do_reset();
        i_req = 4'b1111;
        exp_q = '{0, 1, 2, 3, 0};
        bad = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            #1;
            i_click = ~i_click;
            if (o_pinned !== 1'b0) bad++;
            if (obs_owner_q.size() > 0) begin
                e = exp_q.pop_front();
                ob = obs_owner_q.pop_front();
                void'(obs_grant_q.pop_front());
                void'(obs_led_q.pop_front());
                checks++;
                if (ob !== e) begin errors++; $display("FAIL click_owner got %0d required %0d", ob, e); end
            end
            cyc++;
        end
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL click_owner timeout %0d owners missing", exp_q.size()); end
        if (bad != 0) begin errors++; $display("FAIL click_pinned cycles %0d required 0", bad); end
        for (int i = 0; i < 4 && i < ten_q.size(); i++) begin
            checks++;
            if (ten_q[i] != H + 1) begin errors++; $display("FAIL click_tenure %0d got %0d required %0d", i, ten_q[i], H + 1); end
        end
        i_click = 1'b0;
        i_req = '0;
        wait_idle("click");
    endtask
`endif

    task automatic test_reset_mid_pin();
        bit ok;
        do_reset();
        i_req = 4'b1111;
        wait_obs(ok);
`ifdef LED_ARB_PIN_EN
        i_click = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_click = 1'b0;
        checks++;
        if (o_pinned !== 1'b1) begin errors++; $display("FAIL rst_pin_set got %b required 1", o_pinned); end
`endif
        @(posedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        checks += 5;
        if (o_grant !== '0) begin errors++; $display("FAIL rst_mid_grant got %b required 0000", o_grant); end
        if (o_owner !== '0) begin errors++; $display("FAIL rst_mid_owner got %0d required 0", o_owner); end
        if (o_led !== '0) begin errors++; $display("FAIL rst_mid_led got %h required 00", o_led); end
        if (o_pinned !== 1'b0) begin errors++; $display("FAIL rst_mid_pinned got %b required 0", o_pinned); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b required 0", o_busy); end
        i_req = 4'b0010;
        @(negedge clk);
        #1;
        i_reset = 1'b1;
        clear_queues();
        wait_obs(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_regrant timeout required owner 1");
        end else begin
            checks++;
            if (obs_owner_q.pop_front() !== 1 || obs_grant_q.pop_front() !== 4'b0010) begin
                errors++;
                $display("FAIL rst_regrant got owner %0d grant %b required 1 0010", o_owner, o_grant);
            end
        end
        i_req = '0;
        wait_idle("rst");
    endtask

    initial begin
        i_data[0] = 8'hA5;
        i_data[1] = 8'h3C;
        i_data[2] = 8'h5A;
        i_data[3] = 8'hC3;
        test_reset();
        test_dwell();
        test_rotation();
        test_skip_wrap();
`ifdef LED_ARB_PIN_EN
        test_pin();
`else
        test_click_ignored();
`endif
        test_reset_mid_pin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_share_arbiter.md
# led_share_arbiter

Shares the 8-LED debug display among several on-chip requesters, so multiple debug sources can show state without being rewired. Each requester raises a request and presents its own word. The arbiter grants one owner at a time in round-robin order and enforces a minimum dwell per owner. It also lets the operator freeze ("pin") the current owner with a debounced button click. It sits between the debug sources and the LED output stage, and is fed by the existing button debouncer.

## Interface
- `WIDTH`, 8: display word width.
- `N_REQ`, 4: number of requesters, ≥2.
- `HOLD_CYCLES`, 1024*1024*50: minimum cycles an owner keeps the display, ≥1.
- `clk` in 1: clock.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_req` in `N_REQ`: per-requester request level.
- `i_data` in `WIDTH` × `N_REQ` (unpacked `[N_REQ-1:0]`): per-requester display word.
- `i_click` in 1: debounced button level; the block edge-detects it internally.
- `o_grant` out `N_REQ`: one-hot grant, registered.
- `o_owner` out `$clog2(N_REQ)`: index of the current owner.
- `o_led` out `WIDTH`: registered display word.
- `o_pinned` out 1: pin state active.
- `o_busy` out 1: an owner exists.

## Operation
- States: `IDLE`, `HOLD`, `OPEN`, `PIN`.
- Reset values: state `IDLE`; `o_grant`=0, `o_owner`=0, `o_led`=0, `o_pinned`=0, `o_busy`=0; dwell counter 0; click edge register 0.
- Round-robin pick: scan from `(last_owner+1) mod N_REQ` upward with wrap-around, excluding the current owner. `last_owner` resets to `N_REQ-1`, so the first pick favours index 0.
- `IDLE`: if any `i_req` is high, pick an owner and go to `HOLD` with counter=0. Otherwise stay, with `o_led`=0.
- `HOLD`: the counter increments each cycle. At count == `HOLD_CYCLES-1`, go to `OPEN`. The owner's `i_req` dropping is ignored here; the dwell is guaranteed.
- `OPEN`:
  - Owner req low and another req high: switch to the RR winner, enter `HOLD`.
  - Owner req low and no other req: go to `IDLE`; `o_grant`=0 and `o_led`=0.
  - Owner req high and another req high: rotate to the RR winner, enter `HOLD`.
  - Owner req high alone: stay in `OPEN`.
- `PIN`: entered from `HOLD` or `OPEN` on a click rising edge. The owner is frozen, requests are ignored and the counter holds its value. A click rising edge in `PIN` goes to `OPEN`, and the `OPEN` rules apply on the next cycle.
- A click in `IDLE` is ignored.
- Click and re-arbitration in the same cycle in `OPEN`: pin wins and the owner is unchanged.
- While an owner exists, `o_led` tracks `i_data[owner]` live, including in `PIN`.
- Counter width is `$clog2(HOLD_CYCLES+1)`. It never wraps; it saturates by leaving `HOLD`.
- Asserting reset mid-dwell or mid-pin returns everything to the reset values immediately (asynchronous).

## Timing
- Request sampled high at edge k from `IDLE` → `o_grant`, `o_owner`, `o_busy` and `o_led=i_data[new]` are all valid after edge k. Latency is 1 cycle.
- `o_led` is registered from the next-owner mux. A data change at the input shows one cycle later.
- An owner granted at edge k cannot be displaced before edge k+`HOLD_CYCLES`+1. The earliest switch is one cycle after entering `OPEN`.
- Click rising edge detection adds 1 cycle. A level rising before edge k sets `o_pinned` after edge k+1.
- `o_grant` is always one-hot or zero, never multi-hot.

## Configuration
- `LED_ARB_PIN_EN` defined: the `PIN` state, the click edge detector and `o_pinned` behave as above.
- Not defined: the `PIN` state and edge detector are not compiled. `i_click` is ignored and `o_pinned` is tied 0. All other behaviour is identical.

## Structure
- Shared package `debug_pkg`:
  - `arb_state_t` enum (`IDLE`/`HOLD`/`OPEN`/`PIN`).
  - `function automatic` index-width helper.
  - Default `HOLD_CYCLES` constant.
- One sub-module, `rr_priority_pick`: combinational round-robin picker.
  - Inputs: `req` vector, start index, excluded index.
  - Outputs: `valid` and the winner index.

## Test plan
- Dwell and release:
  - Stimulus: `HOLD_CYCLES`=4, `i_req`=0001, `i_data[0]`=A5; drop req after 1 cycle.
  - Response: grant 0001 and `o_led`=A5 after 1 edge; grant held 4 cycles; then `IDLE` with `o_led`=00.
- Rotation:
  - Stimulus: `i_req`=1111 held.
  - Response: owners 0,1,2,3,0 in order, each held exactly `HOLD_CYCLES`+1 cycles.
- Skip and wrap:
  - Stimulus: owner 3; `i_req`=0101 after dwell.
  - Response: next owner is 0, then 2.
- Pin:
  - Stimulus: click during `HOLD` of owner 1 with `i_req`=1111.
  - Response: `o_pinned`=1; owner stays 1 for 1000 cycles despite requests. A second click → `OPEN`, then rotates to 2.
- Reset mid-pin:
  - Stimulus: assert `i_reset`=0 while pinned.
  - Response: all outputs 0 immediately. After release with `i_req`=0010, owner is 1.
- Macro off:
  - Stimulus: clicks with `LED_ARB_PIN_EN` undefined.
  - Response: `o_pinned` stays 0; rotation is unaffected.
